nec_ir_decoder: RTL

NEC_IR_DECODER -- requirements
Module: nec_ir_decoder

---
 rtl/nec_ir_pkg.sv | 35 +++
 rtl/ir_sync.sv | 36 +++
 rtl/nec_ir_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nec_ir_pkg.sv
// Shared types and half-unit timing windows for the NEC IR decoder.
// All window limits are inclusive and expressed in half-units (UNIT_CYCLES/2 clocks).
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK
    } nec_state_e;

    localparam int HU_W = 8;

    localparam int LEAD_MARK_MIN   = 28;
    localparam int LEAD_MARK_MAX   = 36;
    localparam int LEAD_DATA_MIN   = 14;
    localparam int LEAD_DATA_MAX   = 19;
    localparam int LEAD_RPT_MIN    = 7;
    localparam int LEAD_RPT_MAX    = 10;
    localparam int BIT_MARK_MIN    = 1;
    localparam int BIT_MARK_MAX    = 3;
    localparam int BIT_ZERO_MIN    = 1;
    localparam int BIT_ZERO_MAX    = 3;
    localparam int BIT_ONE_MIN     = 5;
    localparam int BIT_ONE_MAX     = 8;
    localparam int STOP_MARK_MIN   = 1;
    localparam int STOP_MARK_MAX   = 3;

    function automatic logic in_window(input logic [HU_W-1:0] len, input int lo, input int hi);
        return (int'(len) >= lo) && (int'(len) <= hi);
    endfunction

endpackage

// File: rtl/ir_sync.sv
// Two-flop synchronizer for the raw IR input with rise/fall edge pulses.
// Flops reset to 1 so the idle-high line does not produce a spurious edge.
module ir_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_rise = ~prev_q & sync_q;
    assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: measures mark/space phases in half-units and emits address/command.
// Define NEC_IR_STRICT_ADDR_EN to require addr_hi == ~addr_lo and report an 8-bit address.
module nec_ir_decoder #(
    parameter int UNIT_CYCLES = 56250,
    parameter int TIMEOUT_HU  = 40
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ir,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_addr,
    output logic [7:0]  o_cmd,
    output logic        o_repeat,
    output logic        o_overrun
);
    import nec_ir_pkg::*;

    localparam int HALF_UNIT = UNIT_CYCLES / 2;
    localparam int SUB_W     = $clog2(HALF_UNIT + 1);

    logic ir_rise, ir_fall;

    nec_state_e        state_q, state_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [HU_W-1:0]   hu_q, hu_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic              rpt_q, rpt_d;
    logic [15:0]       last_addr_q, last_addr_d;
    logic [7:0]        last_cmd_q, last_cmd_d;
    logic              have_good_q, have_good_d;
    logic              valid_q, valid_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              repeat_q, repeat_d;
    logic              overrun_q, overrun_d;

    logic        frame_done;
    logic        data_ok;
    logic        frame_ok;
    logic [15:0] frame_addr;
    logic        timeout;

    ir_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_ir),
        .o_rise  (ir_rise),
        .o_fall  (ir_fall)
    );

`ifdef NEC_IR_STRICT_ADDR_EN
    assign data_ok    = (shift_q[31:24] == ~shift_q[23:16]) && (shift_q[15:8] == ~shift_q[7:0]);
    assign frame_addr = {8'h00, shift_q[7:0]};
`else
    assign data_ok    = (shift_q[31:24] == ~shift_q[23:16]);
    assign frame_addr = shift_q[15:0];
`endif

    assign frame_ok = rpt_q ? have_good_q : data_ok;
    assign timeout  = (state_q != ST_IDLE) && (int'(hu_q) >= TIMEOUT_HU);

    // Phase timer: sub_q starts at 1 on an edge so hu_q*HALF_UNIT+sub_q equals cycles since that edge.
    always_comb begin
        sub_d = sub_q;
        hu_d  = hu_q;
        if (ir_rise || ir_fall) begin
            sub_d = SUB_W'(1);
            hu_d  = '0;
        end else if (sub_q == SUB_W'(HALF_UNIT - 1)) begin
            sub_d = '0;
            if (hu_q != '1) begin
                hu_d = hu_q + 1'b1;
            end
        end else begin
            sub_d = sub_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rpt_d      = rpt_q;
        frame_done = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ir_fall) state_d = ST_LEAD_MARK;
                end
                ST_LEAD_MARK: begin
                    if (ir_rise) begin
                        state_d = in_window(hu_q, LEAD_MARK_MIN, LEAD_MARK_MAX) ? ST_LEAD_SPACE : ST_IDLE;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (ir_fall) begin
                        if (in_window(hu_q, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
                            state_d   = ST_BIT_MARK;
                            bit_cnt_d = '0;
                            rpt_d     = 1'b0;
                        end else if (in_window(hu_q, LEAD_RPT_MIN, LEAD_RPT_MAX)) begin
                            state_d = ST_STOP_MARK;
                            rpt_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BIT_MARK: begin
                    if (ir_rise) begin
                        state_d = in_window(hu_q, BIT_MARK_MIN, BIT_MARK_MAX) ? ST_BIT_SPACE : ST_IDLE;
                    end
                end
                ST_BIT_SPACE: begin
                    if (ir_fall) begin
                        if (in_window(hu_q, BIT_ZERO_MIN, BIT_ZERO_MAX) ||
                            in_window(hu_q, BIT_ONE_MIN, BIT_ONE_MAX)) begin
                            shift_d   = {in_window(hu_q, BIT_ONE_MIN, BIT_ONE_MAX), shift_q[31:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            state_d   = (bit_cnt_q == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_STOP_MARK: begin
                    if (ir_rise) begin
                        frame_done = in_window(hu_q, STOP_MARK_MIN, STOP_MARK_MAX);
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output slot: a completion may reload the slot in the same cycle the held frame is taken.
    always_comb begin
        valid_d     = valid_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        repeat_d    = repeat_q;
        overrun_d   = 1'b0;
        last_addr_d = last_addr_q;
        last_cmd_d  = last_cmd_q;
        have_good_d = have_good_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (frame_done && frame_ok) begin
            if (!valid_q || i_ready) begin
                valid_d  = 1'b1;
                addr_d   = rpt_q ? last_addr_q : frame_addr;
                cmd_d    = rpt_q ? last_cmd_q : shift_q[23:16];
                repeat_d = rpt_q;
            end else begin
                overrun_d = 1'b1;
            end
            if (!rpt_q) begin
                last_addr_d = frame_addr;
                last_cmd_d  = shift_q[23:16];
                have_good_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            sub_q       <= '0;
            hu_q        <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rpt_q       <= 1'b0;
            last_addr_q <= '0;
            last_cmd_q  <= '0;
            have_good_q <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= '0;
            repeat_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            hu_q        <= hu_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rpt_q       <= rpt_d;
            last_addr_q <= last_addr_d;
            last_cmd_q  <= last_cmd_d;
            have_good_q <= have_good_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            repeat_q    <= repeat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_addr    = addr_q;
    assign o_cmd     = cmd_q;
    assign o_repeat  = repeat_q;
    assign o_overrun = overrun_q;

endmodule
